latch_if_id_skid: RTL and testbench
===================================

// Module: latch_if_id_skid
// PURPOSE
//  Parametrised IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//  Sits between fetch (PC + instruction memory) and decode.
//  Adds what the plain IF/ID latch lacks: per-entry valid bits, a flush that inserts a NOP
//  bubble, full-throughput stall absorption, and a saturating stall counter for debug.
// PARAMETERS
//  B        32            instruction width, bits
//  PC_W     32            pc_incrementado width, bits
//  NOP      32'h00000000  instruction driven on instruction_out while out_valid=0
//  CNT_W    16            stall counter width, bits
// PORTS
//  clk                  in   1      rising-edge clock, single clock domain
//  reset                in   1      asynchronous, active-low; clears all state
//  flush                in   1      sync; discard all held entries (branch/jump taken)
//  in_valid             in   1      fetch presents a valid pc/instruction pair
//  in_ready             out  1      stage can accept; registered, = !FULL
//  pc_incrementado_in   in   PC_W   PC+4 from fetch
//  instruction_in       in   B      fetched instruction
//  out_valid            out  1      decode-side entry valid
//  out_ready            in   1      decode accepts; 0 = hazard stall (replaces disa)
//  pc_incrementado_out  out  PC_W   PC+4 of head entry, 0 when !out_valid
//  instruction_out      out  B      head instruction, NOP when !out_valid
//  stall_count          out  CNT_W  cycles with out_valid=1 && out_ready=0; saturating
// BEHAVIOUR
//  Reset (reset=0, async)
//   - state=EMPTY, out_valid=0, in_ready=1, pc_incrementado_out=0, instruction_out=NOP,
//     stall_count=0.
//   - Reset mid-operation drops all entries immediately; no partial transfer survives.
//  Transfers
//   - accept = in_valid && in_ready
//   - deliver = out_valid && out_ready
//   - Both evaluated at the rising edge.
//  Storage
//   - Two entries: head (drives outputs) and skid.
//   - FSM states: EMPTY / ONE / FULL.
//  Transitions (when flush=0)
//   - EMPTY: accept -> ONE (head <= in), else EMPTY.
//   - ONE: accept & deliver -> ONE (head <= in). accept & !deliver -> FULL (skid <= in).
//     !accept & deliver -> EMPTY. Otherwise hold.
//   - FULL: deliver -> ONE (head <= skid). accept is impossible (in_ready=0). Otherwise hold.
//  Latency and throughput
//   - Latency 1 cycle, in -> out; all outputs registered.
//   - Sustains 1 transfer/cycle while out_ready=1.
//  Stalls
//   - A 1-cycle out_ready drop costs no fetch bubble: the skid entry absorbs it.
//  Flush (highest priority below reset)
//   - Next state EMPTY; out_valid=0, instruction_out=NOP, pc_incrementado_out=0 next cycle.
//   - An entry offered in the flush cycle is discarded even if accept=1.
//   - A head delivered in the flush cycle still counts as delivered.
//   - in_ready=1 the cycle after a flush.
//  Hold
//   - Outputs stay stable while out_valid=1 && out_ready=0 (AXI-style rule).
//   - in_valid must not be withdrawn by fetch once asserted while in_ready=0.
//  stall_count
//   - +1 each cycle with out_valid && !out_ready; saturates at 2^CNT_W-1.
//   - Cleared only by reset; unaffected by flush.
//  Invalid outputs
//   - Head data regs are not cleared on deliver, but the output mux forces
//     instruction_out=NOP and pc_incrementado_out=0 whenever out_valid=0.
//  Widths
//   - No arithmetic on data; pure transport.
//   - Counter is unsigned, compared against all-ones before increment.
// STRUCTURE
//  - Shared package (pipe_pkg.vh): localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2,
//    and the MIPS NOP constant reused by ID/EX and EX/MEM stages.
//  - One natural sub-module: sat_counter (parametrised CNT_W, inc, sat flag), reused by
//    later stages' debug counters.
//  - Datapath (head/skid regs + output mux) stays in this file.
// TESTING
//  1. Reset=0 mid-stream with FULL state -> all outputs at reset values within the same
//     cycle; out_valid=0, in_ready=1 after release.
//  2. Stream 8 instr 0x20080001..0x20080008, out_ready=1 -> out 1 cycle later, in order,
//     8 deliveries in 8 cycles.
//  3. out_ready=0 for 1 cycle mid-stream -> state FULL for one cycle, in_ready=0, no
//     instruction lost or duplicated, stall_count=1.
//  4. out_ready=0 for 5 cycles -> in_ready=0 from cycle 2, outputs frozen, stall_count=5.
//  5. flush=1 while FULL and in_valid=1 -> next cycle out_valid=0, instruction_out=NOP,
//     pc_incrementado_out=0, in_ready=1; offered instr never appears.
//  6. CNT_W=4, hold stall 20 cycles -> stall_count saturates at 15; then flush -> still 15.

Source files
------------

// File: rtl/latch_if_id_skid_pkg.sv
// Shared pipeline definitions for the IF/ID skid stage and later pipeline stages.
//   skid_state_e : occupancy of a 2-entry skid stage (empty / one entry / full)
//   MIPS_NOP     : canonical MIPS no-op (sll $0,$0,0), driven on invalid slots
package latch_if_id_skid_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/latch_if_id_skid_sat_counter.sv
// Saturating up-counter used for debug event counting.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears the count
//   i_inc   : count one event this cycle
//   o_count : current count, sticks at all-ones
//   o_sat   : count has reached all-ones
module latch_if_id_skid_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_count;

  assign o_sat   = (r_count == {CNT_W{1'b1}});
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/latch_if_id_skid.sv
// IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Sits between fetch and decode; absorbs decode stalls without fetch bubbles.
//   clk / rst_n             : clock, asynchronous active-low reset
//   i_flush                 : discard all held entries (taken branch/jump)
//   i_in_valid / o_in_ready : fetch-side handshake (o_in_ready = not full)
//   i_pc_incrementado_in    : PC+4 from fetch
//   i_instruction_in        : fetched instruction
//   o_out_valid / i_out_ready : decode-side handshake (i_out_ready=0 is a hazard stall)
//   o_pc_incrementado_out   : head PC+4, 0 when not valid
//   o_instruction_out       : head instruction, NOP when not valid
//   o_stall_count           : saturating count of valid-but-stalled cycles
//   o_stall_sat             : stall counter has saturated
module latch_if_id_skid
  import latch_if_id_skid_pkg::*;
#(
  parameter int unsigned B     = 32,
  parameter int unsigned PC_W  = 32,
  parameter logic [B-1:0] NOP  = B'(MIPS_NOP),
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [PC_W-1:0]  i_pc_incrementado_in,
  input  logic [B-1:0]     i_instruction_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [PC_W-1:0]  o_pc_incrementado_out,
  output logic [B-1:0]     o_instruction_out,
  output logic [CNT_W-1:0] o_stall_count,
  output logic             o_stall_sat
);

  skid_state_e r_state, w_state_d;

  logic [PC_W-1:0] r_head_pc, r_skid_pc;
  logic [B-1:0]    r_head_instr, r_skid_instr;

  logic w_in_ready, w_out_valid, w_accept, w_deliver;
  logic w_load_head_in, w_load_head_skid, w_load_skid;

  // Handshake flags decode straight from the state register: no input-to-output paths.
  assign w_in_ready  = (r_state != StFull);
  assign w_out_valid = (r_state != StEmpty);
  assign w_accept    = i_in_valid && w_in_ready;
  assign w_deliver   = w_out_valid && i_out_ready;

  always_comb begin
    w_state_d        = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      // Offered entry is dropped even if accepted; a delivered head is already consumed.
      w_state_d = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_state_d      = StOne;
            w_load_head_in = 1'b1;
          end
        end
        StOne: begin
          if (w_accept && w_deliver) begin
            w_load_head_in = 1'b1;
          end else if (w_accept) begin
            w_state_d   = StFull;
            w_load_skid = 1'b1;
          end else if (w_deliver) begin
            w_state_d = StEmpty;
          end
        end
        StFull: begin
          if (w_deliver) begin
            w_state_d        = StOne;
            w_load_head_skid = 1'b1;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Data regs are never cleared on deliver; the output mux hides stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_pc    <= '0;
      r_head_instr <= NOP;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP;
    end else begin
      if (w_load_head_in) begin
        r_head_pc    <= i_pc_incrementado_in;
        r_head_instr <= i_instruction_in;
      end else if (w_load_head_skid) begin
        r_head_pc    <= r_skid_pc;
        r_head_instr <= r_skid_instr;
      end
      if (w_load_skid) begin
        r_skid_pc    <= i_pc_incrementado_in;
        r_skid_instr <= i_instruction_in;
      end
    end
  end

  assign o_in_ready            = w_in_ready;
  assign o_out_valid           = w_out_valid;
  assign o_pc_incrementado_out = w_out_valid ? r_head_pc : '0;
  assign o_instruction_out     = w_out_valid ? r_head_instr : NOP;

  latch_if_id_skid_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_out_valid && !i_out_ready),
    .o_count (o_stall_count),
    .o_sat   (o_stall_sat)
  );

endmodule

// File: tb/tb_latch_if_id_skid.sv
// Scoreboard bench for latch_if_id_skid: stimulus pushes accepted entries into a queue,
// a negedge monitor compares the DUT head against the queue and pops on delivery.
module tb_latch_if_id_skid;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = 15;
  localparam logic [31:0] TB_NOP  = 32'h0000_0000;

  logic             clk;
  logic             rst_n;
  logic             i_flush;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [31:0]      i_pc_incrementado_in;
  logic [31:0]      i_instruction_in;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [31:0]      o_pc_incrementado_out;
  logic [31:0]      o_instruction_out;
  logic [CNT_W-1:0] o_stall_count;
  logic             o_stall_sat;

  latch_if_id_skid #(
    .B     (32),
    .PC_W  (32),
    .NOP   (TB_NOP),
    .CNT_W (CNT_W)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_flush               (i_flush),
    .i_in_valid            (i_in_valid),
    .o_in_ready            (o_in_ready),
    .i_pc_incrementado_in  (i_pc_incrementado_in),
    .i_instruction_in      (i_instruction_in),
    .o_out_valid           (o_out_valid),
    .i_out_ready           (i_out_ready),
    .o_pc_incrementado_out (o_pc_incrementado_out),
    .o_instruction_out     (o_instruction_out),
    .o_stall_count         (o_stall_count),
    .o_stall_sat           (o_stall_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of {pc, instr} entries held by the stage, plus occupancy and count.
  logic [63:0] sb[$];
  int          m_occ = 0;
  int          m_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: mid-cycle, inputs and outputs are both stable for the upcoming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", 64'(o_out_valid), 64'(sb.size() > 0));
        chk("in_ready", 64'(o_in_ready), 64'(m_occ < 2));
        chk("stall_count", 64'(o_stall_count), 64'(m_cnt));
        chk("stall_sat", 64'(o_stall_sat), 64'(m_cnt == CNT_MAX));
        if (sb.size() > 0) begin
          chk("head_instr", 64'(o_instruction_out), 64'(sb[0][31:0]));
          chk("head_pc", 64'(o_pc_incrementado_out), 64'(sb[0][63:32]));
          if (i_out_ready) void'(sb.pop_front());
        end else begin
          chk("idle_instr_nop", 64'(o_instruction_out), 64'(TB_NOP));
          chk("idle_pc_zero", 64'(o_pc_incrementado_out), 64'd0);
        end
      end
    end
  end

  // Applies one cycle of inputs (called #1 after a rising edge), then advances the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic acc, dlv;
    // Fetch may not withdraw or change an offer while the stage is full.
    if (!(i_in_valid && m_occ == 2)) begin
      i_in_valid           = v;
      i_instruction_in     = ins;
      i_pc_incrementado_in = pc;
    end
    i_out_ready = ordy;
    i_flush     = fl;
    @(posedge clk);
    #1;
    acc = i_in_valid && (m_occ < 2);
    dlv = (m_occ > 0) && i_out_ready;
    if (m_occ > 0 && !i_out_ready && m_cnt < CNT_MAX) m_cnt++;
    if (i_flush) begin
      m_occ = 0;
      sb.delete();
    end else begin
      if (dlv) m_occ--;
      if (acc) begin
        m_occ++;
        sb.push_back({i_pc_incrementado_in, i_instruction_in});
      end
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    rst_n      = 1'b0;
    i_in_valid = 1'b0;
    i_flush    = 1'b0;
    #1;
    chk("rst_out_valid", 64'(o_out_valid), 64'd0);
    chk("rst_in_ready", 64'(o_in_ready), 64'd1);
    chk("rst_instr_nop", 64'(o_instruction_out), 64'(TB_NOP));
    chk("rst_pc_zero", 64'(o_pc_incrementado_out), 64'd0);
    chk("rst_stall_count", 64'(o_stall_count), 64'd0);
    m_occ = 0;
    m_cnt = 0;
    sb.delete();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ins;
    rst_n                = 1'b0;
    i_flush              = 1'b0;
    i_in_valid           = 1'b0;
    i_out_ready          = 1'b0;
    i_instruction_in     = 32'h0;
    i_pc_incrementado_in = 32'h0;
    #1;
    chk("por_out_valid", 64'(o_out_valid), 64'd0);
    chk("por_in_ready", 64'(o_in_ready), 64'd1);
    chk("por_stall_count", 64'(o_stall_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back stream at full throughput.
    for (int k = 1; k <= 8; k++) step(1'b1, 32'h2008_0000 + k, 32'h400 + 4 * k, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Single-cycle decode stall mid-stream: skid absorbs it.
    for (int k = 1; k <= 6; k++)
      step(1'b1, 32'h2009_0000 + k, 32'h500 + 4 * k, (k != 3), 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Five-cycle stall with fetch still offering.
    for (int k = 1; k <= 9; k++)
      step(1'b1, 32'h200A_0000 + k, 32'h600 + 4 * k, !(k >= 2 && k <= 6), 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, then flush while full with a pending offer.
    for (int k = 1; k <= 3; k++) step(1'b1, 32'h200B_0000 + k, 32'h700 + 4 * k, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 32'h7FC, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h200B_0010, 32'h800, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset mid-stream while full.
    for (int k = 1; k <= 3; k++) step(1'b1, 32'h200C_0000 + k, 32'h900 + 4 * k, 1'b0, 1'b0);
    pulse_reset();

    // Long stall drives the counter to saturation; flush must not clear it.
    for (int k = 1; k <= 20; k++) step(1'b1, 32'h200D_0000 + k, 32'hA00 + 4 * k, 1'b0, 1'b0);
    step(1'b1, 32'h200D_00FF, 32'hAFC, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h200D_0100, 32'hB00, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    pulse_reset();

    // Randomised traffic with varying stall density, occasional flushes and one reset.
    for (int c = 0; c < 3000; c++) begin
      int unsigned pr;
      pr  = (c / 200) % 3 == 0 ? 2 : ((c / 200) % 3 == 1 ? 6 : 12);
      ins = $urandom;
      if (c == 1500) pulse_reset();
      step(($urandom_range(3, 0) != 0), ins, $urandom, ($urandom_range(15, 0) >= pr),
           ($urandom_range(31, 0) == 0));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
